// File: rtl/alu181_nibble_seq_if.sv
// alu181_nibble_seq_if: request/result bus of the nibble-serial sequencer plus the
// port to the shared 4-bit 74181-style ALU slice.
// The slave modport is the sequencer; the master modport is whoever issues
// requests and owns the ALU slice (datapath control, or a testbench).
interface alu181_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [3:0]       op_s;
  logic             op_m;
  logic             op_ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             eq;
  logic             done;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_ci;
  logic [3:0]       alu_f;
  logic             alu_co;
  logic             alu_aeqb;

  modport slave (
    input  start, op_s, op_m, op_ci, a, b, alu_f, alu_co, alu_aeqb,
    output ready, result, cout, eq, done, alu_a, alu_b, alu_s, alu_m, alu_ci
  );

  modport master (
    output start, op_s, op_m, op_ci, a, b, alu_f, alu_co, alu_aeqb,
    input  ready, result, cout, eq, done, alu_a, alu_b, alu_s, alu_m, alu_ci
  );
endinterface

// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq: runs WIDTH-bit operations through one external 4-bit
// 74181-style ALU slice, one nibble per cycle, LSB first, chaining the slice's
// carry-out back in as the next nibble's (active-low) carry-in.
// Optional feature macro: ALU181_SEQ_CMP_EN -- when defined, eq accumulates the
// slice's A=B output across all nibbles; when undefined eq is tied low.
module alu181_nibble_seq #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  alu181_nibble_seq_if.slave bus
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] aOp_q;
  logic [WIDTH-1:0] bOp_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             done_q;
  logic             ready_q;
  logic [3:0]       aluA_q;
  logic [3:0]       aluB_q;
  logic [3:0]       aluS_q;
  logic             aluM_q;
  logic             aluCi_q;

  logic [IW-1:0]    idx_d;
  logic             lastNib_d;

  // Next nibble index and end-of-operation detect; idx_d is only consumed when
  // another nibble follows, so its wrap on the last nibble never reaches the ALU.
  always_comb begin
    idx_d     = idx_q + 1'b1;
    lastNib_d = (idx_q == LAST_IDX);
  end

`ifdef ALU181_SEQ_CMP_EN
  logic eq_q;

  // Equality accumulator: armed at accept, cleared by any nibble whose slice
  // reports A!=B, then held alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_q <= 1'b0;
    end else if (state_q == IDLE && bus.start && ready_q) begin
      eq_q <= 1'b1;
    end else if (state_q == RUN) begin
      eq_q <= eq_q & bus.alu_aeqb;
    end
  end

  assign bus.eq = eq_q;
`else
  assign bus.eq = 1'b0;
`endif

  // Sequencer FSM. The alu_* outputs are registers loaded from the latched
  // operands, so the slice never sees live bus inputs and keeps its last RUN
  // values while IDLE/DONE. aluCi_q doubles as the running carry register; it is
  // not updated on the last nibble so alu_ci also holds through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      aOp_q    <= '0;
      bOp_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      aluA_q   <= 4'h0;
      aluB_q   <= 4'h0;
      aluS_q   <= 4'h0;
      aluM_q   <= 1'b0;
      aluCi_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && ready_q) begin
            aOp_q    <= bus.a;
            bOp_q    <= bus.b;
            idx_q    <= '0;
            result_q <= '0;
            aluA_q   <= bus.a[3:0];
            aluB_q   <= bus.b[3:0];
            aluS_q   <= bus.op_s;
            aluM_q   <= bus.op_m;
            aluCi_q  <= bus.op_ci;
            ready_q  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[{idx_q, 2'b00} +: 4] <= bus.alu_f;
          if (lastNib_d) begin
            cout_q  <= bus.alu_co;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_d;
            aluA_q  <= aOp_q[{idx_d, 2'b00} +: 4];
            aluB_q  <= bOp_q[{idx_d, 2'b00} +: 4];
            aluCi_q <= ~bus.alu_co;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.alu_a  = aluA_q;
  assign bus.alu_b  = aluB_q;
  assign bus.alu_s  = aluS_q;
  assign bus.alu_m  = aluM_q;
  assign bus.alu_ci = aluCi_q;

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// tb_alu181_nibble_seq: drives the nibble sequencer with directed and random
// operations, emulates the external 74181 slice, and checks every cycle against
// a whole-word model of the 74181 function table.
module tb_alu181_nibble_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int nChecks = 0;
  int nPass   = 0;
  int doneCount = 0;

  alu181_nibble_seq_if #(.WIDTH(W)) bus ();

  alu181_nibble_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // External 74181 slice: gate-level style propagate/generate terms, combinational.
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx   = bus.alu_a | (bus.alu_b & {4{bus.alu_s[0]}}) | (~bus.alu_b & {4{bus.alu_s[1]}});
    sy   = (bus.alu_a & ~bus.alu_b & {4{bus.alu_s[2]}}) | (bus.alu_a & bus.alu_b & {4{bus.alu_s[3]}});
    ssum = {1'b0, sx} + {1'b0, sy} + {4'b0000, ~bus.alu_ci};
    if (bus.alu_m) begin
      bus.alu_f  = ~(sx ^ sy);
      bus.alu_co = 1'b0;
    end else begin
      bus.alu_f  = ssum[3:0];
      bus.alu_co = ssum[4];
    end
    bus.alu_aeqb = (bus.alu_f == 4'hF);
  end

  // ---------------- reference model ----------------
  int           mPhase = 0;
  logic [W-1:0] mA, mB;
  logic [3:0]   mS;
  logic         mM;
  logic         expCi [N];
  logic [W-1:0] pendResult, expResult;
  logic         pendCout, expCout, pendEq, expEq;
  logic [3:0]   hA, hB, hS;
  logic         hM, hCi;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else nPass++;
  endtask

  // Whole-word 74181 evaluation: arithmetic as P plus Q plus carry, logic from the table.
  task automatic modelAccept(input logic [3:0] s, input logic m, input logic ci,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, q, f;
    logic [W:0]   sum;
    logic [63:0]  mask, lo;
    logic         cin;
    mA = a; mB = b; mS = s; mM = m;
    cin = ~ci;
    p = a; q = '0;
    case (s)
      4'd0:  begin p = a;        q = '0;      end
      4'd1:  begin p = a | b;    q = '0;      end
      4'd2:  begin p = a | ~b;   q = '0;      end
      4'd3:  begin p = '0;       q = '1;      end
      4'd4:  begin p = a;        q = a & ~b;  end
      4'd5:  begin p = a | b;    q = a & ~b;  end
      4'd6:  begin p = a;        q = ~b;      end
      4'd7:  begin p = a & ~b;   q = '1;      end
      4'd8:  begin p = a;        q = a & b;   end
      4'd9:  begin p = a;        q = b;       end
      4'd10: begin p = a | ~b;   q = a & b;   end
      4'd11: begin p = a & b;    q = '1;      end
      4'd12: begin p = a;        q = a;       end
      4'd13: begin p = a | b;    q = a;       end
      4'd14: begin p = a | ~b;   q = a;       end
      default: begin p = a;      q = '1;      end
    endcase
    expCi[0] = ci;
    if (m) begin
      case (s)
        4'd0:  f = ~a;
        4'd1:  f = ~(a | b);
        4'd2:  f = ~a & b;
        4'd3:  f = '0;
        4'd4:  f = ~(a & b);
        4'd5:  f = ~b;
        4'd6:  f = a ^ b;
        4'd7:  f = a & ~b;
        4'd8:  f = ~a | b;
        4'd9:  f = ~(a ^ b);
        4'd10: f = b;
        4'd11: f = a & b;
        4'd12: f = '1;
        4'd13: f = a | ~b;
        4'd14: f = a | b;
        default: f = a;
      endcase
      pendCout = 1'b0;
      for (int k = 1; k < N; k++) expCi[k] = 1'b1;
    end else begin
      sum = {1'b0, p} + {1'b0, q} + {{W{1'b0}}, cin};
      f = sum[W-1:0];
      pendCout = sum[W];
      for (int k = 1; k < N; k++) begin
        mask = (64'd1 << (4 * k)) - 64'd1;
        lo = (64'(p) & mask) + (64'(q) & mask) + 64'(cin);
        expCi[k] = ~lo[4 * k];
      end
    end
    pendResult = f;
`ifdef ALU181_SEQ_CMP_EN
    pendEq = &f;
`else
    pendEq = 1'b0;
`endif
    hS = s; hM = m;
  endtask

  // Model timeline: phase 0 idle, 1..N one per RUN nibble, N+1 the done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = 0; expResult = '0; expCout = 1'b0; expEq = 1'b0;
      hA = 4'h0; hB = 4'h0; hS = 4'h0; hM = 1'b0; hCi = 1'b1;
    end else if (mPhase == 0) begin
      if (bus.start) begin
        modelAccept(bus.op_s, bus.op_m, bus.op_ci, bus.a, bus.b);
        expResult = '0;
        mPhase = 1;
      end
    end else if (mPhase <= N) begin
      if (mPhase == N) begin
        expResult = pendResult; expCout = pendCout; expEq = pendEq;
        hA = mA[W-1 -: 4]; hB = mB[W-1 -: 4]; hCi = expCi[N-1];
      end
      mPhase++;
    end else begin
      mPhase = 0;
    end
  end

  // Per-cycle comparison of all DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    int k;
    if (!rst) begin
      check("ready", 64'(bus.ready), 64'(mPhase == 0));
      check("done", 64'(bus.done), 64'(mPhase == N + 1));
      if (mPhase >= 1 && mPhase <= N) begin
        k = mPhase - 1;
        check("run_alu_a", 64'(bus.alu_a), 64'(mA[4 * k +: 4]));
        check("run_alu_b", 64'(bus.alu_b), 64'(mB[4 * k +: 4]));
        check("run_alu_s", 64'(bus.alu_s), 64'(mS));
        check("run_alu_m", 64'(bus.alu_m), 64'(mM));
        check("run_alu_ci", 64'(bus.alu_ci), 64'(expCi[k]));
      end else begin
        check("result", 64'(bus.result), 64'(expResult));
        check("cout", 64'(bus.cout), 64'(expCout));
        check("eq", 64'(bus.eq), 64'(expEq));
        check("hold_alu_a", 64'(bus.alu_a), 64'(hA));
        check("hold_alu_b", 64'(bus.alu_b), 64'(hB));
        check("hold_alu_s", 64'(bus.alu_s), 64'(hS));
        check("hold_alu_m", 64'(bus.alu_m), 64'(hM));
        check("hold_alu_ci", 64'(bus.alu_ci), 64'(hCi));
      end
    end
  end

  // Count every done pulse seen on the bus.
  always @(negedge clk) begin
    if (bus.done === 1'b1) doneCount++;
  end

  // ---------------- stimulus ----------------
  logic capCi [N];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one request in IDLE; returns in the first RUN cycle with operands scrambled.
  task automatic applyStimulus(input logic [3:0] s, input logic m, input logic ci,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_s = s; bus.op_m = m; bus.op_ci = ci; bus.a = a; bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.op_s = 4'($urandom); bus.op_m = 1'($urandom); bus.op_ci = 1'($urandom);
  endtask

  // Run a full operation, recording alu_ci per nibble; returns in the done cycle.
  task automatic runOp(input logic [3:0] s, input logic m, input logic ci,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    applyStimulus(s, m, ci, a, b);
    for (int k = 0; k < N; k++) begin
      capCi[k] = bus.alu_ci;
      tick();
    end
  endtask

  // Literal expectations in the done cycle, then step back to IDLE.
  task automatic checkOutput(input string nm, input logic [W-1:0] res, input logic co, input logic e);
    check({nm, "_done"}, 64'(bus.done), 64'd1);
    check({nm, "_result"}, 64'(bus.result), 64'(res));
    check({nm, "_cout"}, 64'(bus.cout), 64'(co));
    check({nm, "_eq"}, 64'(bus.eq), 64'(e));
    tick();
  endtask

  logic eqOn;
  int   dc0;

  initial begin
`ifdef ALU181_SEQ_CMP_EN
    eqOn = 1'b1;
`else
    eqOn = 1'b0;
`endif
    bus.start = 1'b0; bus.op_s = 4'h0; bus.op_m = 1'b0; bus.op_ci = 1'b1;
    bus.a = '0; bus.b = '0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_alu_ci", 64'(bus.alu_ci), 64'd1);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);

    // Add with carry across a nibble boundary
    runOp(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001);
    check("model_add", 64'(expResult), 64'h0100);
    checkOutput("add1", 16'h0100, 1'b0, 1'b0);

    // Full-width carry ripple, carry-in per nibble 1,0,0,0
    runOp(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    check("ci_n0", 64'(capCi[0]), 64'd1);
    check("ci_n1", 64'(capCi[1]), 64'd0);
    check("ci_n2", 64'(capCi[2]), 64'd0);
    check("ci_n3", 64'(capCi[3]), 64'd0);
    checkOutput("add2", 16'h0000, 1'b1, 1'b0);

    // Logic XOR: carry chain stays inactive
    runOp(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'h0FF0);
    for (int k = 0; k < N; k++) check("xor_ci", 64'(capCi[k]), 64'd1);
    check("model_xor", 64'(expResult), 64'hFF00);
    checkOutput("xor", 16'hFF00, 1'b0, 1'b0);

    // start while busy is ignored; then an immediate start in IDLE is accepted
    dc0 = doneCount;
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h1111);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555;
    tick();
    bus.a = 16'h7777; bus.b = 16'h0101;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    checkOutput("busy", 16'h2345, 1'b0, 1'b0);
    runOp(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h0101);
    checkOutput("b2b", 16'h1010, 1'b0, 1'b0);
    check("busy_done_count", 64'(doneCount - dc0), 64'd2);

    // start held high: re-accepted in the first IDLE cycle after done
    bus.op_s = 4'b1001; bus.op_m = 1'b0; bus.op_ci = 1'b1;
    bus.a = 16'h0001; bus.b = 16'h0002; bus.start = 1'b1;
    tick();
    bus.a = 16'h0010; bus.b = 16'h0020;
    repeat (N) tick();
    check("held1_result", 64'(bus.result), 64'h0003);
    tick();
    check("held_idle_ready", 64'(bus.ready), 64'd1);
    tick();
    check("held_reaccept", 64'(bus.ready), 64'd0);
    bus.start = 1'b0;
    repeat (N) tick();
    checkOutput("held2", 16'h0030, 1'b0, 1'b0);

    // Reset in the second RUN cycle discards the operation
    dc0 = doneCount;
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h5555, 16'h1111);
    tick();
    #1 rst = 1'b1;
    tick();
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    repeat (N + 2) tick();
    check("mid_rst_no_done", 64'(doneCount - dc0), 64'd0);
    runOp(4'b1001, 1'b0, 1'b1, 16'h1111, 16'h2222);
    checkOutput("after_rst", 16'h3333, 1'b0, 1'b0);

    // Equality flag: all nibbles A=B, then only nibble 2 not
    runOp(4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A);
    checkOutput("eq_all", 16'hFFFF, 1'b0, eqOn);
    runOp(4'b0110, 1'b0, 1'b1, 16'hF100, 16'h0000);
    checkOutput("eq_nib2", 16'hF0FF, 1'b1, 1'b0);

    // Random operations, checked cycle by cycle against the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      repeat (N + 1) tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
